timer_periph: RTL

Memory-mapped machine timer that generates the processor's `timer_interrupt` and answers load/store accesses on the same data-bus signals that feed `data_mem`. It holds a 64-bit free-running `mtime` counter with a programmable prescaler, a 64-bit `mtimecmp` compare register and a control/status pair. It raises a level interrupt while `mtime >= mtimecmp`. It sits beside `data_mem` in the memory-writeback stage. The processor selects between the two read-data sources with `hit`.

---
 rtl/timer_periph.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/timer_periph.sv
// Memory-mapped machine timer: 64-bit prescaled mtime, 64-bit mtimecmp,
// CTRL/STATUS registers and a registered level interrupt on mtime >= mtimecmp.
module timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        timer_interrupt
);

  localparam logic [2:0] SEL_MTIME_LO    = 3'd0;
  localparam logic [2:0] SEL_MTIME_HI    = 3'd1;
  localparam logic [2:0] SEL_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] SEL_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] SEL_CTRL        = 3'd4;
  localparam logic [2:0] SEL_STATUS      = 3'd5;
  localparam logic [2:0] MODE_WORD       = 3'b010;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic [7:0]  presc_q, presc_d;
  logic        fired_q, fired_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        irq_q, irq_d;

  logic        in_window;
  logic        legal_word;
  logic        rd_acc;
  logic        wr_acc;
  logic [2:0]  reg_sel;
  logic        we_mtime_lo, we_mtime_hi;
  logic        we_cmp_lo, we_cmp_hi;
  logic        we_ctrl, we_status;
  logic        tick;
  logic        match;

  // Address decode and access qualification
  always_comb begin
    in_window  = (addr[31:5] == BASE_ADDR[31:5]);
    hit        = in_window && (rd_en || wr_en);
    legal_word = (mem_acc_mode == MODE_WORD) && (addr[1:0] == 2'b00);
    rd_acc     = rd_en && hit && legal_word;
    wr_acc     = wr_en && hit && legal_word;
    reg_sel    = addr[4:2];

    we_mtime_lo = wr_acc && (reg_sel == SEL_MTIME_LO);
    we_mtime_hi = wr_acc && (reg_sel == SEL_MTIME_HI);
    we_cmp_lo   = wr_acc && (reg_sel == SEL_MTIMECMP_LO);
    we_cmp_hi   = wr_acc && (reg_sel == SEL_MTIMECMP_HI);
    we_ctrl     = wr_acc && (reg_sel == SEL_CTRL);
    we_status   = wr_acc && (reg_sel == SEL_STATUS);
  end

  // Read mux: zero-latency, returns pre-edge register values
  always_comb begin
    rdata = 32'h0;
    if (rd_acc) begin
      case (reg_sel)
        SEL_MTIME_LO:    rdata = mtime_q[31:0];
        SEL_MTIME_HI:    rdata = mtime_q[63:32];
        SEL_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
        SEL_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
        SEL_CTRL:        rdata = {16'h0, presc_q, 6'h0, ie_q, en_q};
        SEL_STATUS:      rdata = {31'h0, fired_q};
        default:         rdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    tick  = en_q && (pcnt_q == presc_q);
    match = (mtime_q >= mtimecmp_q);
  end

  // Next-state logic; a software write to either mtime half swallows the tick
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    ie_d       = ie_q;
    presc_d    = presc_q;
    pcnt_d     = pcnt_q;
    fired_d    = fired_q;
    irq_d      = ie_q && match;

    if (we_mtime_lo) begin
      mtime_d[31:0] = wdata;
    end else if (we_mtime_hi) begin
      mtime_d[63:32] = wdata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (we_cmp_lo) begin
      mtimecmp_d[31:0] = wdata;
    end
    if (we_cmp_hi) begin
      mtimecmp_d[63:32] = wdata;
    end

    if (we_ctrl) begin
      en_d    = wdata[0];
      ie_d    = wdata[1];
      presc_d = wdata[15:8];
    end

    if (we_ctrl || tick) begin
      pcnt_d = 8'h0;
    end else if (en_q) begin
      pcnt_d = pcnt_q + 8'h1;
    end

    // Set has priority over write-one-to-clear
    if (we_status && wdata[0]) begin
      fired_d = 1'b0;
    end
    if (match) begin
      fired_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      presc_q    <= 8'h0;
      pcnt_q     <= 8'h0;
      fired_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      fired_q    <= fired_d;
      irq_q      <= irq_d;
    end
  end

  assign timer_interrupt = irq_q;

endmodule
